// File: rtl/store_drain_ctrl_if.sv
// Store-drain handshake bundle: LSU store port, ctrl_ram byte write port and load-hazard query.
// The master modport belongs to the LSU/RAM side and the slave modport belongs to store_drain_ctrl.
interface store_drain_ctrl_if #(
  parameter int DEPTH_LOG = 2
);
  logic                 st_valid;
  logic                 st_ready;
  logic [31:0]          st_addr;
  logic [31:0]          st_data;
  logic [2:0]           st_len;
  logic                 mem_write;
  logic [31:0]          mem_w_addr;
  logic [7:0]           mem_w_data;
  logic                 writting;
  logic                 io_buffer_full;
  logic [31:0]          ld_addr;
  logic [2:0]           ld_len;
  logic                 ld_block;
  logic                 sb_empty;
  logic [DEPTH_LOG:0]   sb_count;

  modport master (
    output st_valid, st_addr, st_data, st_len, writting, io_buffer_full, ld_addr, ld_len,
    input  st_ready, mem_write, mem_w_addr, mem_w_data, ld_block, sb_empty, sb_count
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_len, writting, io_buffer_full, ld_addr, ld_len,
    output st_ready, mem_write, mem_w_addr, mem_w_data, ld_block, sb_empty, sb_count
  );
endinterface

// File: rtl/store_drain_ctrl.sv
// Committed-store FIFO that drains one byte per granted cycle toward ctrl_ram, with IO pacing.
// Macro STORE_DRAIN_LDCHK_EN: when defined, ld_block uses address-overlap checking; otherwise it blocks whenever stores are pending.
module store_drain_ctrl #(
  parameter int DEPTH_LOG = 2
) (
  input  logic             clk,
  input  logic             rst,
  store_drain_ctrl_if.slave sd
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] DEPTH_CNT = (DEPTH_LOG+1)'(DEPTH);

  logic [31:0]          addr_q [DEPTH];
  logic [31:0]          addr_d [DEPTH];
  logic [31:0]          data_q [DEPTH];
  logic [31:0]          data_d [DEPTH];
  logic [2:0]           len_q  [DEPTH];
  logic [2:0]           len_d  [DEPTH];

  logic [DEPTH_LOG-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic [1:0]           bidx_q, bidx_d;
  logic                 io_gap_q, io_gap_d;

  logic                 empty, push, pop, grant, last_byte, io_head;
  logic [31:0]          h_addr, h_data;
  logic [2:0]           h_len;

  assign empty     = (count_q == '0);
  assign h_addr    = addr_q[head_q];
  assign h_data    = data_q[head_q];
  assign h_len     = len_q[head_q];

  assign sd.st_ready   = !rst && (count_q < DEPTH_CNT);
  assign sd.mem_w_addr = h_addr + {30'b0, bidx_q};
  assign sd.mem_w_data = h_data[{bidx_q, 3'b000} +: 8];
  assign io_head       = (sd.mem_w_addr[17:16] == 2'b11);
  assign sd.mem_write  = !empty && !(io_head && (sd.io_buffer_full || io_gap_q));
  assign sd.sb_empty   = empty;
  assign sd.sb_count   = count_q;

  // Zero-length stores complete the handshake but never occupy an entry.
  assign push      = sd.st_valid && sd.st_ready && (sd.st_len != 3'd0);
  assign grant     = sd.mem_write && sd.writting;
  assign last_byte = ({1'b0, bidx_q} == (h_len - 3'd1));
  assign pop       = grant && last_byte;

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    len_d    = len_q;
    head_d   = head_q;
    tail_d   = tail_q;
    bidx_d   = bidx_q;
    io_gap_d = grant && io_head;
    count_d  = count_q + {{DEPTH_LOG{1'b0}}, push} - {{DEPTH_LOG{1'b0}}, pop};
    if (push) begin
      addr_d[tail_q] = sd.st_addr;
      data_d[tail_q] = sd.st_data;
      len_d[tail_q]  = sd.st_len;
      tail_d         = tail_q + DEPTH_LOG'(1);
    end
    if (grant) begin
      if (last_byte) begin
        bidx_d = 2'd0;
        head_d = head_q + DEPTH_LOG'(1);
      end else begin
        bidx_d = bidx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      bidx_q   <= 2'd0;
      io_gap_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      bidx_q   <= bidx_d;
      io_gap_q <= io_gap_d;
    end
  end

  // Entry payload needs no reset; validity comes solely from head/count.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    len_q  <= len_d;
  end

`ifdef STORE_DRAIN_LDCHK_EN
  logic                 ld_hit;
  logic                 ld_io;
  logic [32:0]          ld_lo, ld_hi, e_lo, e_hi;
  logic [DEPTH_LOG-1:0] offs;

  // Head entry keeps its full original range, so already-drained bytes still count as hazards.
  always_comb begin
    ld_hit = 1'b0;
    ld_lo  = {1'b0, sd.ld_addr};
    ld_hi  = ld_lo + 33'(sd.ld_len);
    ld_io  = (sd.ld_addr[17:16] == 2'b11);
    e_lo   = '0;
    e_hi   = '0;
    offs   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = DEPTH_LOG'(i) - head_q;
      if ({1'b0, offs} < count_q) begin
        e_lo = {1'b0, addr_q[i]};
        e_hi = e_lo + 33'(len_q[i]);
        if ((e_lo < ld_hi) && (ld_lo < e_hi)) ld_hit = 1'b1;
        if (ld_io && (addr_q[i][17:16] == 2'b11)) ld_hit = 1'b1;
      end
    end
  end

  assign sd.ld_block = !rst && (sd.ld_len != 3'd0) && ld_hit;
`else
  logic unused_ld_addr;
  assign unused_ld_addr = ^sd.ld_addr;
  assign sd.ld_block    = !rst && (sd.ld_len != 3'd0) && !empty;
`endif

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Directed bench for store_drain_ctrl: drain order, fill/backpressure, IO pacing, partial grants, load hazard, reset mid-drain.
// Inputs change on the falling edge, outputs are sampled on the falling edge plus 1 time unit.
module tb_store_drain_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  store_drain_ctrl_if #(.DEPTH_LOG(2)) sd_if ();
  store_drain_ctrl #(.DEPTH_LOG(2)) dut (.clk(clk), .rst(rst), .sd(sd_if));

  always #5 clk = ~clk;

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] l);
    sd_if.st_valid = 1'b1;
    sd_if.st_addr  = a;
    sd_if.st_data  = d;
    sd_if.st_len   = l;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sd_if.st_valid = 1'b0; sd_if.st_addr = '0; sd_if.st_data = '0; sd_if.st_len = '0;
    sd_if.writting = 1'b0; sd_if.io_buffer_full = 1'b0;
    sd_if.ld_addr = 32'h200; sd_if.ld_len = 3'd4;
    repeat (2) @(negedge clk);
    #1;
    if (sd_if.st_ready !== 1'b0) begin $display("FAIL rst_st_ready got %b exp 0", sd_if.st_ready); n_fail++; end
    n_checks++;
    if (sd_if.ld_block !== 1'b0) begin $display("FAIL rst_ld_block got %b exp 0", sd_if.ld_block); n_fail++; end
    n_checks++;
    rst = 1'b0;
    #1;
    if (sd_if.st_ready !== 1'b1) begin $display("FAIL post_rst_st_ready got %b exp 1", sd_if.st_ready); n_fail++; end
    n_checks++;
    if (sd_if.mem_write !== 1'b0) begin $display("FAIL rst_mem_write got %b exp 0", sd_if.mem_write); n_fail++; end
    n_checks++;
    if (sd_if.sb_empty !== 1'b1) begin $display("FAIL rst_sb_empty got %b exp 1", sd_if.sb_empty); n_fail++; end
    n_checks++;
    if (sd_if.sb_count !== 3'd0) begin $display("FAIL rst_sb_count got %0d exp 0", sd_if.sb_count); n_fail++; end
    n_checks++;
    sd_if.ld_len = 3'd0;
  endtask

  task automatic test_word_drain();
    logic [31:0] d;
    d = 32'hAABBCCDD;
    @(negedge clk);
    sd_if.writting = 1'b1;
    drive_store(32'h100, d, 3'd4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sd_if.st_valid = 1'b0;
      #1;
      if (sd_if.mem_write !== 1'b1) begin $display("FAIL word_mw[%0d] got %b exp 1", k, sd_if.mem_write); n_fail++; end
      n_checks++;
      if (sd_if.mem_w_addr !== 32'h100 + k) begin $display("FAIL word_addr[%0d] got %h exp %h", k, sd_if.mem_w_addr, 32'h100 + k); n_fail++; end
      n_checks++;
      if (sd_if.mem_w_data !== d[8*k +: 8]) begin $display("FAIL word_data[%0d] got %h exp %h", k, sd_if.mem_w_data, d[8*k +: 8]); n_fail++; end
      n_checks++;
    end
    @(negedge clk);
    #1;
    if (sd_if.sb_empty !== 1'b1) begin $display("FAIL word_empty got %b exp 1", sd_if.sb_empty); n_fail++; end
    n_checks++;
    if (sd_if.mem_write !== 1'b0) begin $display("FAIL word_mw_idle got %b exp 0", sd_if.mem_write); n_fail++; end
    n_checks++;
    sd_if.writting = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_store(32'h1000 + 32'(16 * i), 32'h10 + 32'(i), 3'd1);
      #1;
      if (sd_if.st_ready !== (i < 4)) begin $display("FAIL fill_ready[%0d] got %b exp %b", i, sd_if.st_ready, (i < 4)); n_fail++; end
      n_checks++;
    end
    @(negedge clk);
    #1;
    if (sd_if.sb_count !== 3'd4) begin $display("FAIL fill_count got %0d exp 4", sd_if.sb_count); n_fail++; end
    n_checks++;
    if (sd_if.st_ready !== 1'b0) begin $display("FAIL fill_full_ready got %b exp 0", sd_if.st_ready); n_fail++; end
    n_checks++;
    if (sd_if.mem_w_addr !== 32'h1000) begin $display("FAIL fill_head_addr got %h exp 1000", sd_if.mem_w_addr); n_fail++; end
    n_checks++;
    sd_if.writting = 1'b1;
    @(negedge clk);
    #1;
    if (sd_if.sb_count !== 3'd3) begin $display("FAIL fill_pop_count got %0d exp 3", sd_if.sb_count); n_fail++; end
    n_checks++;
    if (sd_if.st_ready !== 1'b1) begin $display("FAIL fill_pop_ready got %b exp 1", sd_if.st_ready); n_fail++; end
    n_checks++;
    if (sd_if.mem_w_addr !== 32'h1010) begin $display("FAIL fill_addr1 got %h exp 1010", sd_if.mem_w_addr); n_fail++; end
    n_checks++;
    @(negedge clk);
    sd_if.st_valid = 1'b0;
    #1;
    if (sd_if.sb_count !== 3'd3) begin $display("FAIL fill_pushpop_count got %0d exp 3", sd_if.sb_count); n_fail++; end
    n_checks++;
    for (int k = 2; k < 5; k++) begin
      if (sd_if.mem_w_addr !== 32'h1000 + 32'(16 * k)) begin $display("FAIL fill_addr[%0d] got %h exp %h", k, sd_if.mem_w_addr, 32'h1000 + 32'(16 * k)); n_fail++; end
      n_checks++;
      if (sd_if.mem_w_data !== 8'h10 + 8'(k)) begin $display("FAIL fill_data[%0d] got %h exp %h", k, sd_if.mem_w_data, 8'h10 + 8'(k)); n_fail++; end
      n_checks++;
      @(negedge clk);
      #1;
    end
    if (sd_if.sb_empty !== 1'b1) begin $display("FAIL fill_empty got %b exp 1", sd_if.sb_empty); n_fail++; end
    n_checks++;
    sd_if.writting = 1'b0;
  endtask

  task automatic test_io_pacing();
    @(negedge clk);
    sd_if.writting = 1'b1;
    sd_if.io_buffer_full = 1'b1;
    drive_store(32'h30000, 32'h0000BEEF, 3'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sd_if.st_valid = 1'b0;
      #1;
      if (sd_if.mem_write !== 1'b0) begin $display("FAIL io_full_mw[%0d] got %b exp 0", k, sd_if.mem_write); n_fail++; end
      n_checks++;
    end
    sd_if.io_buffer_full = 1'b0;
    #1;
    if (sd_if.mem_write !== 1'b1 || sd_if.mem_w_data !== 8'hEF) begin $display("FAIL io_byte0 got mw=%b data=%h exp mw=1 data=ef", sd_if.mem_write, sd_if.mem_w_data); n_fail++; end
    n_checks++;
    @(negedge clk);
    #1;
    if (sd_if.mem_write !== 1'b0) begin $display("FAIL io_gap_mw got %b exp 0", sd_if.mem_write); n_fail++; end
    n_checks++;
    if (sd_if.mem_w_addr !== 32'h30001) begin $display("FAIL io_gap_addr got %h exp 30001", sd_if.mem_w_addr); n_fail++; end
    n_checks++;
    @(negedge clk);
    #1;
    if (sd_if.mem_write !== 1'b1 || sd_if.mem_w_data !== 8'hBE) begin $display("FAIL io_byte1 got mw=%b data=%h exp mw=1 data=be", sd_if.mem_write, sd_if.mem_w_data); n_fail++; end
    n_checks++;
    @(negedge clk);
    #1;
    if (sd_if.sb_empty !== 1'b1) begin $display("FAIL io_empty got %b exp 1", sd_if.sb_empty); n_fail++; end
    n_checks++;
    sd_if.writting = 1'b0;
  endtask

  task automatic test_partial_grant();
    logic [6:0]  pat;
    logic [31:0] d;
    int          eb;
    pat = 7'b1010101;
    d   = 32'h44332211;
    eb  = 0;
    @(negedge clk);
    drive_store(32'h400, d, 3'd4);
    @(negedge clk);
    sd_if.st_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1;
      if (sd_if.mem_w_addr !== 32'h400 + 32'(eb)) begin $display("FAIL pg_addr[%0d] got %h exp %h", k, sd_if.mem_w_addr, 32'h400 + 32'(eb)); n_fail++; end
      n_checks++;
      if (sd_if.mem_w_data !== d[8*eb +: 8]) begin $display("FAIL pg_data[%0d] got %h exp %h", k, sd_if.mem_w_data, d[8*eb +: 8]); n_fail++; end
      n_checks++;
      sd_if.writting = pat[k];
      if (pat[k]) eb++;
      @(negedge clk);
    end
    sd_if.writting = 1'b0;
    #1;
    if (sd_if.sb_empty !== 1'b1) begin $display("FAIL pg_empty got %b exp 1", sd_if.sb_empty); n_fail++; end
    n_checks++;
  endtask

  task automatic test_ld_block();
    logic exp_far;
`ifdef STORE_DRAIN_LDCHK_EN
    exp_far = 1'b0;
`else
    exp_far = 1'b1;
`endif
    @(negedge clk);
    sd_if.ld_addr = 32'h202; sd_if.ld_len = 3'd1;
    #1;
    if (sd_if.ld_block !== 1'b0) begin $display("FAIL ld_empty got %b exp 0", sd_if.ld_block); n_fail++; end
    n_checks++;
    drive_store(32'h200, 32'h12345678, 3'd4);
    @(negedge clk);
    sd_if.st_valid = 1'b0;
    #1;
    if (sd_if.ld_block !== 1'b1) begin $display("FAIL ld_overlap got %b exp 1", sd_if.ld_block); n_fail++; end
    n_checks++;
    sd_if.ld_addr = 32'h204; sd_if.ld_len = 3'd4;
    #1;
    if (sd_if.ld_block !== exp_far) begin $display("FAIL ld_adjacent got %b exp %b", sd_if.ld_block, exp_far); n_fail++; end
    n_checks++;
    sd_if.ld_addr = 32'h202; sd_if.ld_len = 3'd0;
    #1;
    if (sd_if.ld_block !== 1'b0) begin $display("FAIL ld_len0 got %b exp 0", sd_if.ld_block); n_fail++; end
    n_checks++;
    sd_if.writting = 1'b1;
    repeat (4) @(negedge clk);
    sd_if.writting = 1'b0;
    #1;
    if (sd_if.sb_empty !== 1'b1) begin $display("FAIL ld_drain_empty got %b exp 1", sd_if.sb_empty); n_fail++; end
    n_checks++;
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk);
    sd_if.writting = 1'b1;
    drive_store(32'h500, 32'h88776655, 3'd4);
    @(negedge clk);
    sd_if.st_valid = 1'b0;
    @(negedge clk);
    #1;
    if (sd_if.mem_w_data !== 8'h66) begin $display("FAIL rmd_byte1 got %h exp 66", sd_if.mem_w_data); n_fail++; end
    n_checks++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    if (sd_if.mem_write !== 1'b0) begin $display("FAIL rmd_mw got %b exp 0", sd_if.mem_write); n_fail++; end
    n_checks++;
    if (sd_if.sb_count !== 3'd0) begin $display("FAIL rmd_count got %0d exp 0", sd_if.sb_count); n_fail++; end
    n_checks++;
    if (sd_if.sb_empty !== 1'b1) begin $display("FAIL rmd_empty got %b exp 1", sd_if.sb_empty); n_fail++; end
    n_checks++;
    drive_store(32'h600, 32'hDDCCBBAA, 3'd4);
    @(negedge clk);
    sd_if.st_valid = 1'b0;
    #1;
    if (sd_if.mem_w_addr !== 32'h600 || sd_if.mem_w_data !== 8'hAA) begin $display("FAIL rmd_restart got %h/%h exp 600/aa", sd_if.mem_w_addr, sd_if.mem_w_data); n_fail++; end
    n_checks++;
    repeat (4) @(negedge clk);
    #1;
    if (sd_if.sb_empty !== 1'b1) begin $display("FAIL rmd_final_empty got %b exp 1", sd_if.sb_empty); n_fail++; end
    n_checks++;
    sd_if.writting = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word_drain();
    test_back_to_back();
    test_io_pacing();
    test_partial_grant();
    test_ld_block();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
